// File: rtl/glyph_scan.sv
// Raster scan generator: walks the pixel grid one pixel per enabled clock and
// emits sync, data-enable, coarse column (with a counter-tracked mod-3) and row.
module glyph_scan #(
  parameter int   H_ACTIVE = 480,
  parameter int   H_FRONT  = 16,
  parameter int   H_SYNC   = 64,
  parameter int   H_BACK   = 40,
  parameter int   V_ACTIVE = 360,
  parameter int   V_FRONT  = 3,
  parameter int   V_SYNC   = 4,
  parameter int   V_BACK   = 13,
  parameter int   SCALE    = 4,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [6:0] col,
  output logic [1:0] col_mod3,
  output logic [8:0] row,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [SW-1:0] S_LAST = SW'(SCALE - 1);

  logic [HW-1:0] hcnt, h_nxt;
  logic [VW-1:0] vcnt, v_nxt;
  logic [SW-1:0] sub, sub_nxt;
  logic [6:0]    col_nxt;
  logic [1:0]    mod_nxt;
  logic          de_nxt;

  // Outputs are registered from the next-state counters so all of them
  // describe the same hcnt/vcnt position.
  always_comb begin
    h_nxt = (hcnt == H_LAST) ? '0 : hcnt + HW'(1);
    v_nxt = vcnt;
    if (hcnt == H_LAST)
      v_nxt = (vcnt == V_LAST) ? '0 : vcnt + VW'(1);
    de_nxt  = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    sub_nxt = '0;
    col_nxt = '0;
    mod_nxt = '0;
    // Only advance when staying inside an active run; entering one restarts at 0.
    if (de_nxt && de) begin
      if (sub == S_LAST) begin
        col_nxt = col + 7'd1;
        mod_nxt = (col_mod3 == 2'd2) ? 2'd0 : col_mod3 + 2'd1;
      end else begin
        sub_nxt = sub + SW'(1);
        col_nxt = col;
        mod_nxt = col_mod3;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt        <= '0;
      vcnt        <= '0;
      sub         <= '0;
      de          <= 1'b1;
      col         <= '0;
      col_mod3    <= '0;
      row         <= '0;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
    end else if (en) begin
      hcnt        <= h_nxt;
      vcnt        <= v_nxt;
      sub         <= sub_nxt;
      de          <= de_nxt;
      col         <= col_nxt;
      col_mod3    <= mod_nxt;
      row         <= (v_nxt < V_ACT) ? 9'(v_nxt) : '0;
      line_start  <= (h_nxt == '0);
      frame_start <= (h_nxt == '0) && (v_nxt == '0);
      hsync       <= (h_nxt >= HS_BEG && h_nxt < HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (v_nxt >= VS_BEG && v_nxt < VS_END) ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: tb/tb_glyph_scan.sv
// Directed bench for glyph_scan: default instance, a short-frame instance and a SCALE=5 instance.
module tb_glyph_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  logic       hs_a, vs_a, de_a, ls_a, fs_a;
  logic [6:0] col_a;
  logic [1:0] mod_a;
  logic [8:0] row_a;
  logic       hs_b, vs_b, de_b, ls_b, fs_b;
  logic [6:0] col_b;
  logic [1:0] mod_b;
  logic [8:0] row_b;
  logic       hs_c, vs_c, de_c, ls_c, fs_c;
  logic [6:0] col_c;
  logic [1:0] mod_c;
  logic [8:0] row_c;

  glyph_scan u_a (
    .clk(clk), .rst(rst), .en(en), .hsync(hs_a), .vsync(vs_a), .de(de_a),
    .col(col_a), .col_mod3(mod_a), .row(row_a), .line_start(ls_a), .frame_start(fs_a));

  glyph_scan #(.V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .hsync(hs_b), .vsync(vs_b), .de(de_b),
    .col(col_b), .col_mod3(mod_b), .row(row_b), .line_start(ls_b), .frame_start(fs_b));

  glyph_scan #(.SCALE(5), .H_ACTIVE(600)) u_c (
    .clk(clk), .rst(rst), .en(en), .hsync(hs_c), .vsync(vs_c), .de(de_c),
    .col(col_c), .col_mod3(mod_c), .row(row_c), .line_start(ls_c), .frame_start(fs_c));

  // {de, col, col_mod3, row, line_start, frame_start, hsync, vsync}
  wire [22:0] obs_a = {de_a, col_a, mod_a, row_a, ls_a, fs_a, hs_a, vs_a};
  wire [22:0] obs_b = {de_b, col_b, mod_b, row_b, ls_b, fs_b, hs_b, vs_b};
  wire [22:0] obs_c = {de_c, col_c, mod_c, row_c, ls_c, fs_c, hs_c, vs_c};
  localparam logic [22:0] RST_V = 23'h40000F;

  int h_a, v_a, v_b, h_c, v_c;

  function automatic logic [22:0] model(input int h, input int v, input int hact,
      input int scale, input int vact, input int vfront, input int vsw);
    logic d;
    int c;
    d = (h < hact) && (v < vact);
    c = d ? h / scale : 0;
    return {d, 7'(c), 2'(c % 3), 9'((v < vact) ? v : 0), (h == 0), (h == 0 && v == 0),
            !(h >= hact + 16 && h < hact + 80),
            !(v >= vact + vfront && v < vact + vfront + vsw)};
  endfunction

  function automatic logic [22:0] exp_a();
    return model(h_a, v_a, 480, 4, 360, 3, 4);
  endfunction
  function automatic logic [22:0] exp_b();
    return model(h_a, v_b, 480, 4, 6, 1, 2);
  endfunction
  function automatic logic [22:0] exp_c();
    return model(h_c, v_c, 600, 5, 360, 3, 4);
  endfunction

  task automatic step(input logic e);
    en = e;
    @(posedge clk);
    #1;
    if (e) begin
      if (h_a == 599) begin
        h_a = 0;
        v_a = (v_a == 379) ? 0 : v_a + 1;
        v_b = (v_b == 9) ? 0 : v_b + 1;
      end else h_a++;
      if (h_c == 719) begin
        h_c = 0;
        v_c = (v_c == 379) ? 0 : v_c + 1;
      end else h_c++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    h_a = 0; v_a = 0; v_b = 0; h_c = 0; v_c = 0;
    for (int i = 0; i < 700; i++) step(1'b1);
    rst = 1'b1;
    #1;
    checks++; if (obs_a !== RST_V) begin failures++; $display("FAIL reset_async_a: got %h want %h", obs_a, RST_V); end
    checks++; if (obs_b !== RST_V) begin failures++; $display("FAIL reset_async_b: got %h want %h", obs_b, RST_V); end
    checks++; if (obs_c !== RST_V) begin failures++; $display("FAIL reset_async_c: got %h want %h", obs_c, RST_V); end
    en = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (obs_a !== RST_V) begin failures++; $display("FAIL reset_held: got %h want %h", obs_a, RST_V); end
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    h_a = 0; v_a = 0; v_b = 0; h_c = 0; v_c = 0;
    for (int i = 0; i < 5; i++) step(1'b1);
    checks++; if ({de_a, col_a, mod_a, ls_a} !== {1'b1, 7'd1, 2'd1, 1'b0})
      begin failures++; $display("FAIL reset_5pulses_a: got %b want %b", {de_a, col_a, mod_a, ls_a}, {1'b1, 7'd1, 2'd1, 1'b0}); end
    checks++; if ({col_c, mod_c} !== {7'd1, 2'd1})
      begin failures++; $display("FAIL reset_5pulses_c: got %b want %b", {col_c, mod_c}, {7'd1, 2'd1}); end
  endtask

  task automatic test_column_sweep();
    for (int i = 0; i < 595; i++) begin
      step(1'b1);
      checks++; if (obs_a !== exp_a()) begin failures++; $display("FAIL sweep h=%0d: got %h want %h", h_a, obs_a, exp_a()); end
      if (h_a >= 476 && h_a <= 479) begin
        checks++; if ({col_a, mod_a} !== {7'd119, 2'd2})
          begin failures++; $display("FAIL last_col h=%0d: got %0d/%0d want 119/2", h_a, col_a, mod_a); end
      end
      if (h_a == 480) begin
        checks++; if ({de_a, col_a} !== 8'd0)
          begin failures++; $display("FAIL de_fall: got de=%b col=%0d want 0/0", de_a, col_a); end
      end
    end
    checks++; if ({row_a, ls_a} !== {9'd1, 1'b1})
      begin failures++; $display("FAIL row_inc: got row=%0d ls=%b want 1/1", row_a, ls_a); end
  endtask

  task automatic test_hsync();
    int low_cnt, first_low, last_low, ls_cnt, ls_pos;
    low_cnt = 0; first_low = -1; last_low = -1; ls_cnt = 0; ls_pos = -1;
    for (int i = 0; i < 600; i++) begin
      if (hs_a == 1'b0) begin
        low_cnt++;
        if (first_low < 0) first_low = h_a;
        last_low = h_a;
      end
      if (ls_a) begin
        ls_cnt++;
        ls_pos = h_a;
      end
      step(1'b1);
    end
    checks++; if (low_cnt !== 64) begin failures++; $display("FAIL hsync_width: got %0d want 64", low_cnt); end
    checks++; if (first_low !== 496 || last_low !== 559)
      begin failures++; $display("FAIL hsync_span: got %0d..%0d want 496..559", first_low, last_low); end
    checks++; if (ls_cnt !== 1 || ls_pos !== 0)
      begin failures++; $display("FAIL line_start: got cnt=%0d pos=%0d want 1/0", ls_cnt, ls_pos); end
    checks++; if (row_a !== 9'd2) begin failures++; $display("FAIL row_line2: got %0d want 2", row_a); end
  endtask

  task automatic test_frame_wrap();
    logic prev_vs;
    logic done;
    int vs_cnt, vs_first, vs_last;
    done = 1'b0; vs_cnt = 0; vs_first = -1; vs_last = -1;
    for (int i = 0; i < 7000 && !done; i++) begin
      prev_vs = vs_b;
      step(1'b1);
      checks++; if (obs_b !== exp_b()) begin failures++; $display("FAIL frame v=%0d h=%0d: got %h want %h", v_b, h_a, obs_b, exp_b()); end
      checks++; if (vs_b !== prev_vs && h_a != 0)
        begin failures++; $display("FAIL vsync_edge: changed at h=%0d want h=0", h_a); end
      if (vs_b == 1'b0) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = v_b;
        vs_last = v_b;
      end
      done = (h_a == 0 && v_b == 0);
    end
    checks++; if (!done) begin failures++; $display("FAIL frame_wrap_timeout: got done=%b want 1", done); end
    checks++; if ({fs_b, row_b, de_b} !== {1'b1, 9'd0, 1'b1})
      begin failures++; $display("FAIL frame_start: got fs=%b row=%0d de=%b want 1/0/1", fs_b, row_b, de_b); end
    checks++; if (vs_cnt !== 1200 || vs_first !== 7 || vs_last !== 8)
      begin failures++; $display("FAIL vsync_lines: got %0d cyc lines %0d..%0d want 1200 lines 7..8", vs_cnt, vs_first, vs_last); end
  endtask

  task automatic test_en_gating();
    logic [22:0] prev_a, prev_c;
    logic e;
    for (int i = 0; i < 4000; i++) begin
      prev_a = obs_a;
      prev_c = obs_c;
      e = ($urandom_range(0, 9) < 3);
      step(e);
      if (!e) begin
        checks++; if ({obs_a, obs_c} !== {prev_a, prev_c})
          begin failures++; $display("FAIL en_hold: got %h/%h want %h/%h", obs_a, obs_c, prev_a, prev_c); end
      end else begin
        checks++; if ({obs_a, obs_c} !== {exp_a(), exp_c()})
          begin failures++; $display("FAIL en_step: got %h/%h want %h/%h", obs_a, obs_c, exp_a(), exp_c()); end
      end
    end
  endtask

  task automatic test_param_variant();
    for (int i = 0; i < 800 && h_c != 0; i++) step(1'b1);
    checks++; if (h_c !== 0) begin failures++; $display("FAIL c_align: got h=%0d want 0", h_c); end
    for (int i = 0; i < 720; i++) begin
      step(1'b1);
      checks++; if (obs_c !== exp_c()) begin failures++; $display("FAIL scale5 h=%0d: got %h want %h", h_c, obs_c, exp_c()); end
      if (h_c == 599 && v_c < 360) begin
        checks++; if ({de_c, col_c, mod_c} !== {1'b1, 7'd119, 2'd2})
          begin failures++; $display("FAIL scale5_end: got %0d/%0d want 119/2", col_c, mod_c); end
      end
      if (h_c == 600) begin
        checks++; if ({de_c, col_c} !== 8'd0)
          begin failures++; $display("FAIL scale5_de_fall: got de=%b col=%0d want 0/0", de_c, col_c); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_column_sweep();
    test_hsync();
    test_frame_wrap();
    test_en_gating();
    test_param_variant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
